alu_inverse: RTL and testbench

ALU_INVERSE -- requirements
Module: alu_inverse

---
 rtl/alu_pkg.sv | 7 +
 rtl/alu_div_seq.sv | 58 +++++
 rtl/alu_inverse.sv | 82 ++++++++
 tb/tb_alu_inverse.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, operand/result widths and FSM encoding shared by the inverse ALU and its bench.
package alu_pkg;
    localparam int W = 3;
    localparam int ZW = 6;
    typedef enum logic [1:0] {OP_ADD = 2'b00, OP_MUL = 2'b01, OP_AND = 2'b10, OP_OR = 2'b11} op_t;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/alu_div_seq.sv
// alu_div_seq: 6/3-bit restoring divider; one quotient bit per clock, first bit on the start edge.
module alu_div_seq
    import alu_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [ZW-1:0] dividend,
    input  logic [W-1:0]  divisor,
    output logic          done,
    output logic [ZW-1:0] quotient,
    output logic [W-1:0]  remainder
);
    logic [W-1:0]  d, r, r_in, d_in, r_nx;
    logic [ZW-1:0] q, q_in, q_nx;
    logic [W:0]    t, diff;
    logic [2:0]    cnt;
    logic          run, ge;
    always_comb begin
        r_in = start ? '0 : r;
        q_in = start ? dividend : q;
        d_in = start ? divisor : d;
        t    = {r_in, q_in[ZW-1]};
        diff = t - {1'b0, d_in};
        ge   = t >= {1'b0, d_in};
        r_nx = ge ? diff[W-1:0] : t[W-1:0];
        q_nx = {q_in[ZW-2:0], ge};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d    <= '0;
            r    <= '0;
            q    <= '0;
            cnt  <= '0;
            run  <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                r   <= r_nx;
                q   <= q_nx;
                d   <= divisor;
                cnt <= 3'd1;
                run <= 1'b1;
            end else if (run) begin
                r   <= r_nx;
                q   <= q_nx;
                cnt <= cnt + 3'd1;
                if (cnt == 3'(ZW - 1)) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end
    assign quotient  = q;
    assign remainder = r;
endmodule

// File: rtl/alu_inverse.sv
// alu_inverse: recovers x from z = fwd(op, x, y); op mul uses the sequential divider only
// when ALU_INVERSE_DIV_EN is defined, otherwise mul always reports err.
module alu_inverse
    import alu_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [ZW-1:0] z,
    input  logic [W-1:0]  y,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  x,
    output logic          err
);
    state_t        state, state_nx;
    op_t           op_q;
    logic [ZW-1:0] z_q;
    logic [W-1:0]  y_q, r_x, mul_x;
    logic [ZW:0]   diff;
    logic          cap, calc_done, r_err, mul_err, mul_done;
    assign cap = state == IDLE && start;
`ifdef ALU_INVERSE_DIV_EN
    logic          div_done;
    logic [ZW-1:0] quo;
    logic [W-1:0]  rem;
    alu_div_seq u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (cap && op == OP_MUL && y != '0),
        .dividend  (z),
        .divisor   (y),
        .done      (div_done),
        .quotient  (quo),
        .remainder (rem)
    );
    assign mul_done = y_q == '0 || div_done;
    assign mul_err  = y_q == '0 || rem != '0 || quo[ZW-1:W] != '0;
    assign mul_x    = quo[W-1:0];
`else
    assign mul_done = 1'b1;
    assign mul_err  = 1'b1;
    assign mul_x    = '0;
`endif
    always_comb begin
        diff      = {1'b0, z_q} - {{(ZW-W+1){1'b0}}, y_q};
        calc_done = op_q == OP_MUL ? mul_done : 1'b1;
        r_err     = op_q == OP_ADD ? (diff[ZW] || diff[ZW-1:W] != '0) :
                    op_q == OP_MUL ? mul_err :
                    op_q == OP_AND ? (z_q[ZW-1:W] != '0 || (z_q[W-1:0] & ~y_q) != '0) :
                                     (z_q[ZW-1:W] != '0 || (y_q & ~z_q[W-1:0]) != '0);
        r_x       = op_q == OP_ADD ? diff[W-1:0] :
                    op_q == OP_MUL ? mul_x :
                    op_q == OP_AND ? z_q[W-1:0] : z_q[W-1:0] & ~y_q;
        state_nx  = state == IDLE ? (start ? CALC : IDLE) :
                    state == CALC ? (calc_done ? DONE : CALC) : IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            op_q  <= OP_ADD;
            z_q   <= '0;
            y_q   <= '0;
            x     <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nx;
            if (cap) begin
                op_q <= op_t'(op);
                z_q  <= z;
                y_q  <= y;
            end
            if (state == CALC && calc_done) begin
                x   <= r_err ? '0 : r_x;
                err <= r_err;
            end
        end
    end
    assign busy = state != IDLE;
    assign done = state == DONE;
endmodule

// File: tb/tb_alu_inverse.sv
// tb_alu_inverse: scoreboard bench; stimulus pushes expected results, a negedge monitor checks each done.
module tb_alu_inverse;
    import alu_pkg::*;
`ifdef ALU_INVERSE_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif
    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [1:0] op = '0;
    logic [5:0] z = '0;
    logic [2:0] y = '0;
    logic       busy, done, err;
    logic [2:0] x;
    int         cyc = 0, tests = 0, fails = 0;
    typedef struct {
        bit         prop;
        logic [1:0] op;
        logic [2:0] y;
        logic [5:0] z;
        logic [2:0] x;
        logic       e;
        int         due;
    } exp_t;
    exp_t       sb[$];
    logic [2:0] last_x = '0;
    logic       last_e = 1'b0;
    bit         last_ok = 1'b1;

    alu_inverse dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .z     (z),
        .y     (y),
        .busy  (busy),
        .done  (done),
        .x     (x),
        .err   (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [5:0] fwd(input logic [1:0] o, input logic [2:0] a, input logic [2:0] b);
        return o == OP_ADD ? {3'b0, a} + {3'b0, b} :
               o == OP_MUL ? {3'b0, a} * {3'b0, b} :
               o == OP_AND ? {3'b0, a & b} : {3'b0, a | b};
    endfunction

    function automatic int lat_of(input logic [1:0] o, input logic [2:0] b);
        return (o == OP_MUL && DIV_EN && b != 3'd0) ? 7 : 2;
    endfunction

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc + 1);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 6'd1, 6'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_cycle", 6'(cyc + 1 - e.due + 32), 6'd32);
                if (e.prop) begin
                    check("err_prop", {5'b0, err}, 6'd0);
                    check("fwd_x", fwd(e.op, x, e.y), e.z);
                end else begin
                    check("x", {3'b0, x}, {3'b0, e.x});
                    check("err", {5'b0, err}, {5'b0, e.e});
                end
            end
        end
    end

    task automatic drive(input logic [1:0] o, input logic [5:0] zz, input logic [2:0] yy);
        op = o;
        z = zz;
        y = yy;
        start = 1'b1;
    endtask

    task automatic scramble();
        start = 1'b0;
        op = 2'($urandom);
        z = 6'($urandom);
        y = 3'($urandom);
    endtask

    task automatic issue(input logic [1:0] o, input logic [5:0] zz, input logic [2:0] yy,
                         input bit prop, input logic [2:0] ex, input logic ee);
        int lat;
        lat = lat_of(o, yy);
        if (last_ok) begin
            check("hold_x", {3'b0, x}, {3'b0, last_x});
            check("hold_err", {5'b0, err}, {5'b0, last_e});
        end
        drive(o, zz, yy);
        sb.push_back('{prop, o, yy, zz, ex, ee, cyc + 1 + lat});
        @(negedge clk);
        scramble();
        repeat (lat) @(negedge clk);
        last_ok = !prop;
        last_x = ex;
        last_e = ee;
    endtask

    initial begin
        #1;
        check("rst_busy", {5'b0, busy}, 6'd0);
        check("rst_done", {5'b0, done}, 6'd0);
        check("rst_x", {3'b0, x}, 6'd0);
        check("rst_err", {5'b0, err}, 6'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(OP_ADD, 6'd12, 3'd5, 1'b0, 3'd7, 1'b0);
        issue(OP_ADD, 6'd13, 3'd5, 1'b0, 3'd0, 1'b1);
        issue(OP_ADD, 6'd3, 3'd5, 1'b0, 3'd0, 1'b1);
        issue(OP_ADD, 6'd5, 3'd5, 1'b0, 3'd0, 1'b0);
        issue(OP_MUL, 6'd42, 3'd6, 1'b0, DIV_EN ? 3'd7 : 3'd0, !DIV_EN);
        issue(OP_MUL, 6'd43, 3'd6, 1'b0, 3'd0, 1'b1);
        issue(OP_MUL, 6'd48, 3'd6, 1'b0, 3'd0, 1'b1);
        issue(OP_MUL, 6'd0, 3'd0, 1'b0, 3'd0, 1'b1);
        issue(OP_AND, 6'd2, 3'd6, 1'b0, 3'd2, 1'b0);
        issue(OP_AND, 6'd3, 3'd6, 1'b0, 3'd0, 1'b1);
        issue(OP_AND, 6'd10, 3'd7, 1'b0, 3'd0, 1'b1);
        issue(OP_OR, 6'd7, 3'd5, 1'b0, 3'd2, 1'b0);
        issue(OP_OR, 6'd6, 3'd5, 1'b0, 3'd0, 1'b1);
        // second start while busy must be dropped; the first result is the only done
        drive(OP_MUL, 6'd42, 3'd6);
        sb.push_back('{1'b0, OP_MUL, 3'd6, 6'd42, DIV_EN ? 3'd7 : 3'd0, !DIV_EN, cyc + 1 + lat_of(OP_MUL, 3'd6)});
        @(negedge clk);
        scramble();
        repeat (DIV_EN ? 2 : 1) @(negedge clk);
        drive(OP_ADD, 6'd12, 3'd5);
        @(negedge clk);
        scramble();
        repeat (DIV_EN ? 5 : 2) @(negedge clk);
        check("busy_after_ignore", {5'b0, busy}, 6'd0);
        check("sb_drained", 6'(sb.size()), 6'd0);
        // reset mid-operation aborts silently and clears the held result
        drive(OP_MUL, 6'd42, 3'd6);
        @(negedge clk);
        scramble();
        repeat (DIV_EN ? 3 : 0) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {5'b0, busy}, 6'd0);
        check("abort_done", {5'b0, done}, 6'd0);
        check("abort_x", {3'b0, x}, 6'd0);
        check("abort_err", {5'b0, err}, 6'd0);
        drive(OP_ADD, 6'd12, 3'd5);
        repeat (3) @(negedge clk);
        check("rst_held_busy", {5'b0, busy}, 6'd0);
        scramble();
        rst_n = 1'b1;
        last_x = '0;
        last_e = 1'b0;
        last_ok = 1'b1;
        repeat (8) @(negedge clk);
        check("no_done_after_abort", {5'b0, busy}, 6'd0);
        issue(OP_ADD, 6'd12, 3'd5, 1'b0, 3'd7, 1'b0);
        for (int oi = 0; oi < 4; oi++)
            for (int xi = 0; xi < 8; xi++)
                for (int yi = 0; yi < 8; yi++) begin
                    logic [1:0] o;
                    logic [2:0] a, b;
                    o = 2'(oi);
                    a = 3'(xi);
                    b = 3'(yi);
                    if (o == OP_MUL && (!DIV_EN || b == 3'd0))
                        issue(o, fwd(o, a, b), b, 1'b0, 3'd0, 1'b1);
                    else
                        issue(o, fwd(o, a, b), b, 1'b1, 3'd0, 1'b0);
                end
        repeat (4) @(negedge clk);
        check("final_sb_empty", 6'(sb.size()), 6'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, %0d entries pending", sb.size());
        $fatal(1);
    end
endmodule
